zeroheti_rst_ctrl: RTL and testbench

//  Reset sequencer for the zeroHETI FPGA top. Gates the clock-wizard "locked" indication and orders reset

---
 rtl/zeroheti_rst_pkg.sv | 28 ++
 rtl/zeroheti_sync_2ff.sv | 25 ++
 rtl/zeroheti_rst_ctrl.sv | 168 ++++++++++++++++
 tb/tb_zeroheti_rst_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_rst_pkg.sv
// Shared types for the zeroHETI reset sequencer: FSM states, reset-cause codes
// and a small helper used to size the shared stage counter.
package zeroheti_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        REL_DBG,
        REL_PERIPH,
        REL_CORE,
        RUN,
        NDM
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR,
        CAUSE_LOCK_LOSS,
        CAUSE_NDM,
        CAUSE_WDT
    } rst_cause_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/zeroheti_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset; output resets to 0,
// so an asynchronous input is seen as deasserted until two clean samples land.
module zeroheti_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/zeroheti_rst_ctrl.sv
// zeroHETI reset sequencer: PLL-lock qualification, ordered dbg/periph/core release,
// ndmreset handling. Optional watchdog enabled by defining ZH_RSTCTRL_WDT_EN.
//
//   state      | meaning
//   WAIT_LOCK  | all resets asserted, counting consecutive synced-locked cycles
//   REL_DBG    | debug module released
//   REL_PERIPH | debug + peripherals/interconnect released
//   REL_CORE   | debug + peripherals + core released
//   RUN        | everything released, sys_ready_o high
//   NDM        | periph/core held in reset, debug kept alive
module zeroheti_rst_ctrl
    import zeroheti_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned NDM_MIN_CYCLES     = 8,
    parameter int unsigned WDT_CYCLES         = 2**20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       ndmreset_i,
    input  logic       wdt_kick_i,
    output logic       dbg_rst_no,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic       sys_ready_o,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned CNT_MAX = max3(LOCK_STABLE_CYCLES, STAGE_DELAY, NDM_MIN_CYCLES);
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] NDM_LAST   = CW'(NDM_MIN_CYCLES - 1);

    rst_state_e    r_state, w_state_nxt;
    rst_cause_e    r_cause, w_cause_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_lk;
    logic          w_wdt_expire;
    logic          r_dbg_rst_n, r_periph_rst_n, r_core_rst_n, r_ready;

    zeroheti_sync_2ff u_lock_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (pll_locked_i),
        .o_q   (w_lk)
    );

`ifdef ZH_RSTCTRL_WDT_EN
    localparam int unsigned          WW       = $clog2(WDT_CYCLES) + 1;
    localparam logic [WW-1:0]        WDT_LAST = WW'(WDT_CYCLES - 1);
    logic [WW-1:0]                   r_wdt;

    // Counts only while the FSM stays in RUN, so it is back at 0 before it could wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdt <= '0;
        end else if (r_state == RUN && w_state_nxt == RUN && !wdt_kick_i) begin
            r_wdt <= r_wdt + 1'b1;
        end else begin
            r_wdt <= '0;
        end
    end

    assign w_wdt_expire = (r_wdt == WDT_LAST) && !wdt_kick_i;
`else
    logic w_unused;
    assign w_unused     = wdt_kick_i | (WDT_CYCLES == 0);
    assign w_wdt_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        if (r_state != WAIT_LOCK && !w_lk) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_cause_nxt = CAUSE_LOCK_LOSS;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (!w_lk) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        w_state_nxt = REL_DBG;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                REL_DBG: begin
                    if (r_cnt == STAGE_LAST) begin
                        w_state_nxt = REL_PERIPH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                REL_PERIPH, REL_CORE: begin
                    if (ndmreset_i) begin
                        w_state_nxt = NDM;
                        w_cnt_nxt   = '0;
                        w_cause_nxt = CAUSE_NDM;
                    end else if (r_cnt == STAGE_LAST) begin
                        w_state_nxt = (r_state == REL_PERIPH) ? REL_CORE : RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_cnt_nxt = '0;
                    if (ndmreset_i) begin
                        w_state_nxt = NDM;
                        w_cause_nxt = CAUSE_NDM;
                    end else if (w_wdt_expire) begin
                        w_state_nxt = NDM;
                        w_cause_nxt = CAUSE_WDT;
                    end
                end
                NDM: begin
                    // A watchdog-initiated NDM does not wait for the debugger's request to drop.
                    if (r_cnt >= NDM_LAST && (!ndmreset_i || r_cause == CAUSE_WDT)) begin
                        w_state_nxt = REL_PERIPH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt < NDM_LAST) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= WAIT_LOCK;
            r_cnt          <= '0;
            r_cause        <= CAUSE_POR;
            r_dbg_rst_n    <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_cause        <= w_cause_nxt;
            r_dbg_rst_n    <= (w_state_nxt != WAIT_LOCK);
            r_periph_rst_n <= (w_state_nxt inside {REL_PERIPH, REL_CORE, RUN});
            r_core_rst_n   <= (w_state_nxt inside {REL_CORE, RUN});
            r_ready        <= (w_state_nxt == RUN);
        end
    end

    assign dbg_rst_no    = r_dbg_rst_n;
    assign periph_rst_no = r_periph_rst_n;
    assign core_rst_no   = r_core_rst_n;
    assign sys_ready_o   = r_ready;
    assign rst_cause_o   = r_cause;

endmodule

// File: tb/tb_zeroheti_rst_ctrl.sv
// Bench for zeroheti_rst_ctrl: timeline model checked every cycle plus hand-computed
// release timings. Watchdog expectations follow ZH_RSTCTRL_WDT_EN.
module tb_zeroheti_rst_ctrl;

    localparam int LSC = 8;
    localparam int SD  = 4;
    localparam int NMC = 3;
    localparam int WDT = 32;

`ifdef ZH_RSTCTRL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       pll  = 1'b0;
    logic       ndm  = 1'b0;
    logic       kick = 1'b0;
    logic       dbg_n, per_n, core_n, ready;
    logic [1:0] cause;

    int total = 0;
    int bad   = 0;
    int n_prn = 0;

    always #5 clk = ~clk;

    zeroheti_rst_ctrl #(
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_DELAY        (SD),
        .NDM_MIN_CYCLES     (NMC),
        .WDT_CYCLES         (WDT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_locked_i  (pll),
        .ndmreset_i    (ndm),
        .wdt_kick_i    (kick),
        .dbg_rst_no    (dbg_n),
        .periph_rst_no (per_n),
        .core_rst_no   (core_n),
        .sys_ready_o   (ready),
        .rst_cause_o   (cause)
    );

    // Timeline model: m_t is the position in the release sequence (-1 = waiting for
    // lock, 0 dbg out, SD periph out, 2*SD core out, 3*SD running); m_ndm counts NDM hold.
    int m_s1, m_s2, m_stable, m_t, m_ndm, m_idle, m_cause;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_t = -1; m_ndm = -1; m_idle = 0; m_cause = 0;
    endtask

    function automatic bit m_running();
        return (m_t == 3*SD) && (m_ndm < 0);
    endfunction

    task automatic model_step();
        int lk;
        bit was_run;
        lk      = m_s2;
        was_run = m_running();
        m_s2    = m_s1;
        m_s1    = int'(pll);
        if (m_t < 0) begin
            if (lk == 0) m_stable = 0;
            else if (m_stable == LSC-1) begin m_t = 0; m_stable = 0; end
            else m_stable++;
        end else if (lk == 0) begin
            m_t = -1; m_stable = 0; m_ndm = -1; m_cause = 1;
        end else if (m_ndm >= 0) begin
            if (m_ndm >= NMC-1 && (!ndm || m_cause == 3)) begin m_ndm = -1; m_t = SD; end
            else if (m_ndm < NMC-1) m_ndm++;
        end else if (ndm && m_t >= SD) begin
            m_ndm = 0; m_cause = 2;
        end else if (WDT_ON && was_run && m_idle == WDT-1 && !kick) begin
            m_ndm = 0; m_cause = 3;
        end else if (m_t < 3*SD) begin
            m_t++;
        end
        m_idle = (was_run && m_running()) ? (kick ? 0 : m_idle + 1) : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        logic e_dbg, e_per, e_core, e_rdy;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_dbg  = (m_t >= 0);
                e_per  = (m_t >= SD) && (m_ndm < 0);
                e_core = (m_t >= 2*SD) && (m_ndm < 0);
                e_rdy  = m_running();
                total++;
                if (dbg_n !== e_dbg || per_n !== e_per || core_n !== e_core ||
                    ready !== e_rdy || cause !== 2'(m_cause)) begin
                    bad++;
                    if (n_prn < 20)
                        $display("FAIL model_cycle @%0t got dbg/per/core/rdy/cause=%b%b%b%b/%0d want %b%b%b%b/%0d",
                                 $time, dbg_n, per_n, core_n, ready, cause,
                                 e_dbg, e_per, e_core, e_rdy, m_cause);
                    n_prn++;
                end
                total++;
                if (!((!core_n || per_n) && (!per_n || dbg_n))) begin
                    bad++;
                    if (n_prn < 20)
                        $display("FAIL release_order @%0t got dbg/per/core=%b%b%b want ordered",
                                 $time, dbg_n, per_n, core_n);
                    n_prn++;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic sel_out(input int which);
        case (which)
            0:       return dbg_n;
            1:       return per_n;
            2:       return core_n;
            default: return ready;
        endcase
    endfunction

    // Edges until the selected output reaches val; -1 if the bound expires.
    task automatic edges_until(input int which, input logic val, input int lim, output int n);
        n = 0;
        while (sel_out(which) !== val && n < lim) begin
            tick(1);
            n++;
        end
        if (sel_out(which) !== val) n = -1;
    endtask

    initial begin
        int n;
        @(posedge clk);
        #2;
        tick(2);
        check("por_dbg", int'(dbg_n), 0);
        check("por_periph", int'(per_n), 0);
        check("por_core", int'(core_n), 0);
        check("por_ready", int'(ready), 0);
        check("por_cause", int'(cause), 0);

        // Locked from the first cycle after reset.
        rst = 1'b0; pll = 1'b1;
        edges_until(0, 1'b1, 50, n); check("first_dbg_release", n, 10);
        edges_until(1, 1'b1, 50, n); check("dbg_to_periph", n, 4);
        edges_until(2, 1'b1, 50, n); check("periph_to_core", n, 4);
        edges_until(3, 1'b1, 50, n); check("core_to_ready", n, 4);
        check("run_cause", int'(cause), 0);

        // Lock loss in RUN.
        tick(5);
        pll = 1'b0;
        edges_until(0, 1'b0, 20, n); check("lockloss_latency", n, 3);
        check("lockloss_core", int'(core_n), 0);
        check("lockloss_cause", int'(cause), 1);
        pll = 1'b1;
        edges_until(0, 1'b1, 50, n); check("relock_dbg", n, 10);
        edges_until(3, 1'b1, 50, n); check("relock_ready", n, 12);

        // Single-cycle ndmreset pulse in RUN.
        tick(3);
        ndm = 1'b1; tick(1); ndm = 1'b0;
        check("ndm_periph_low", int'(per_n), 0);
        check("ndm_dbg_kept", int'(dbg_n), 1);
        check("ndm_cause", int'(cause), 2);
        edges_until(1, 1'b1, 20, n); check("ndm_periph_back", n, 3);
        check("ndm_core_still_low", int'(core_n), 0);
        edges_until(2, 1'b1, 20, n); check("ndm_core_back", n, 4);
        edges_until(3, 1'b1, 20, n); check("ndm_ready_back", n, 4);

        // ndmreset in the same cycle the synced lock drop reaches the FSM.
        tick(3);
        pll = 1'b0; tick(2);
        ndm = 1'b1; tick(1); ndm = 1'b0;
        check("collide_dbg", int'(dbg_n), 0);
        check("collide_cause", int'(cause), 1);
        pll = 1'b1;
        edges_until(3, 1'b1, 60, n); check("collide_resequence", n, 22);

        // Asynchronous reset in the middle of the sequence.
        rst = 1'b1; pll = 1'b0; tick(2);
        rst = 1'b0; pll = 1'b1; tick(15);
        check("mid_seq_periph_up", int'(per_n), 1);
        rst = 1'b1;
        #1;
        check("async_rst_dbg", int'(dbg_n), 0);
        check("async_rst_periph", int'(per_n), 0);
        check("async_rst_cause", int'(cause), 0);
        pll = 1'b0;
        tick(1);

        // One-cycle lock glitch after 5 counted cycles restarts qualification.
        rst = 1'b0; pll = 1'b1; tick(7);
        pll = 1'b0; tick(1); pll = 1'b1;
        edges_until(0, 1'b1, 50, n); check("glitch_dbg_release", n + 8, 18);
        edges_until(3, 1'b1, 50, n); check("glitch_ready", n, 12);

        // Kicked every 20 cycles: never times out.
        repeat (5) begin
            tick(19);
            kick = 1'b1; tick(1); kick = 1'b0;
        end
        check("kicked_ready", int'(ready), 1);
        check("kicked_cause", int'(cause), 0);

        // No kick for 40 cycles.
        tick(40);
        check("nokick_cause", int'(cause), WDT_ON ? 3 : 0);
        check("nokick_ready", int'(ready), WDT_ON ? 0 : 1);
        edges_until(3, 1'b1, 30, n); check("nokick_recovers", int'(n >= 0), 1);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
